// File: rtl/bcd_disp_counter.sv
// bcd_disp_counter: 4-digit BCD up/down counter with count/scan prescalers feeding an LED scanner.
// Define LZB_EN to build registered leading-zero blanking; otherwise Dig_blank is tied to 4'b0000.
module bcd_disp_counter #(
    parameter int CNT_DIV  = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic        Up,
    input  logic        Load,
    input  logic [15:0] Load_dat,
    output logic [15:0] Dig_dat,
    output logic [3:0]  Dig_blank,
    output logic        Scan_tick,
    output logic        Carry
);
    localparam int CW = $clog2(CNT_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [15:0]   dig_q, dig_d, stp_d, ld_d;
    logic          carry_q, carry_d, tick_q, tick_d, step, wrap;
    // wrap ripples through the digits: it stays set while every lower digit rolled over
    always_comb begin
        wrap = 1'b1;
        stp_d = dig_q;
        ld_d = Load_dat;
        for (int i = 0; i < 4; i++) begin
            ld_d[4*i+:4] = Load_dat[4*i+:4] > 4'd9 ? 4'd0 : Load_dat[4*i+:4];
            if (wrap) begin
                stp_d[4*i+:4] = Up ? (dig_q[4*i+:4] == 4'd9 ? 4'd0 : dig_q[4*i+:4] + 4'd1)
                                   : (dig_q[4*i+:4] == 4'd0 ? 4'd9 : dig_q[4*i+:4] - 4'd1);
                wrap = dig_q[4*i+:4] == (Up ? 4'd9 : 4'd0);
            end
        end
    end
    always_comb begin
        scan_d = scan_q == SW'(SCAN_DIV - 1) ? '0 : scan_q + SW'(1);
        tick_d = scan_d == SW'(SCAN_DIV - 1);
        step = En && cnt_q == CW'(CNT_DIV - 1);
        cnt_d = (Load || step) ? '0 : En ? cnt_q + CW'(1) : cnt_q;
        dig_d = Load ? ld_d : step ? stp_d : dig_q;
        carry_d = !Load && step && wrap;
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            scan_q <= '0;
            dig_q <= '0;
            carry_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            scan_q <= scan_d;
            dig_q <= dig_d;
            carry_q <= carry_d;
            tick_q <= tick_d;
        end
    end
    assign Dig_dat = dig_q;
    assign Carry = carry_q;
    assign Scan_tick = tick_q;
`ifdef LZB_EN
    logic [3:0] blank_q, blank_d;
    // derived from dig_d so the mask lands on the same edge as the digits
    always_comb blank_d = {dig_d[15:12] == 4'd0, dig_d[15:8] == 8'd0, dig_d[15:4] == 12'd0, 1'b0};
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) blank_q <= 4'b1110;
        else blank_q <= blank_d;
    end
    assign Dig_blank = blank_q;
`else
    assign Dig_blank = 4'b0000;
`endif
endmodule

// File: tb/tb_bcd_disp_counter.sv
// tb_bcd_disp_counter: integer-level model of the display counter checked every cycle, plus directed literal checks.
module tb_bcd_disp_counter;
    localparam int CNT_DIV = 4;
    localparam int SCAN_DIV = 3;
`ifdef LZB_EN
    localparam logic [3:0] BLANK_RST = 4'b1110;
`else
    localparam logic [3:0] BLANK_RST = 4'b0000;
`endif
    logic        Clk, Reset, En, Up, Load;
    logic [15:0] Load_dat, Dig_dat;
    logic [3:0]  Dig_blank;
    logic        Scan_tick, Carry;
    int n_pass = 0, n_chk = 0;
    bit done = 0;
    int m_val = 0, m_ecnt = 0, m_scnt = 0;
    bit m_carry = 0, m_tick = 0;

    bcd_disp_counter #(.CNT_DIV(CNT_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .Load_dat(Load_dat),
        .Dig_dat(Dig_dat), .Dig_blank(Dig_blank), .Scan_tick(Scan_tick), .Carry(Carry)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int bcd2int(input logic [15:0] d);
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + ((d[4*i+:4] > 9) ? 0 : int'(d[4*i+:4]));
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] exp_blank(input int v);
`ifdef LZB_EN
        return {v < 1000, v < 100, v < 10, 1'b0};
`else
        return (v < 0) ? 4'b1111 : 4'b0000;
`endif
    endfunction

    // model: counts clock edges and enabled cycles directly instead of tracking prescaler registers
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_val = 0; m_ecnt = 0; m_scnt = 0; m_carry = 0; m_tick = 0;
        end else begin
            bit stp;
            stp = En && (m_ecnt % CNT_DIV == CNT_DIV - 1);
            m_scnt++;
            m_tick = (m_scnt % SCAN_DIV) == SCAN_DIV - 1;
            m_carry = 0;
            if (Load) begin
                m_val = bcd2int(Load_dat);
                m_ecnt = 0;
            end else begin
                if (En) m_ecnt++;
                if (stp && Up) begin m_carry = (m_val == 9999); m_val = (m_val + 1) % 10000; end
                if (stp && !Up) begin m_carry = (m_val == 0); m_val = (m_val + 9999) % 10000; end
            end
        end
    end

    always begin
        @(posedge Clk);
        #1;
        if (!Reset && !done) begin
            chk("cyc_dig", Dig_dat, int2bcd(m_val));
            chk("cyc_carry", Carry, m_carry);
            chk("cyc_tick", Scan_tick, m_tick);
            chk("cyc_blank", Dig_blank, exp_blank(m_val));
        end
    end

    initial begin
        int k;
        Reset = 1; En = 0; Up = 1; Load = 0; Load_dat = 0;
        #2;
        chk("rst_dig", Dig_dat, 16'h0000);
        chk("rst_carry", Carry, 0);
        chk("rst_tick", Scan_tick, 0);
        chk("rst_blank", Dig_blank, BLANK_RST);
        @(negedge Clk); @(negedge Clk);
        Reset = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            chk("idle_tick", Scan_tick, (i % 3 == 2));
            chk("idle_carry", Carry, 0);
        end
        chk("idle_dig", Dig_dat, 16'h0000);
        En = 1; Up = 1;
        repeat (39) @(negedge Clk);
        chk("count_39", Dig_dat, 16'h0009);
        @(negedge Clk);
        chk("count_40", Dig_dat, 16'h0010);
        Load = 1; Load_dat = 16'h9998;
        @(negedge Clk);
        Load = 0;
        chk("load_9998", Dig_dat, 16'h9998);
        repeat (3) @(negedge Clk);
        chk("hold_9998", Dig_dat, 16'h9998);
        @(negedge Clk);
        chk("step_9999", Dig_dat, 16'h9999);
        chk("no_carry_9999", Carry, 0);
        repeat (4) @(negedge Clk);
        chk("wrap_up_dat", Dig_dat, 16'h0000);
        chk("wrap_up_carry", Carry, 1);
        @(negedge Clk);
        chk("carry_one_cycle", Carry, 0);
        Up = 0;
        k = 0;
        while (Dig_dat !== 16'h9999 && k < 12) begin @(negedge Clk); k++; end
        chk("wrap_dn_dat", Dig_dat, 16'h9999);
        chk("wrap_dn_carry", Carry, 1);
        k = 0;
        while (m_ecnt % CNT_DIV != CNT_DIV - 1 && k < 8) begin @(negedge Clk); k++; end
        chk("found_step_cycle", (m_ecnt % CNT_DIV), CNT_DIV - 1);
        Load = 1; Load_dat = 16'h12F4; Up = 1;
        @(negedge Clk);
        Load = 0;
        chk("load_on_step_dat", Dig_dat, 16'h1204);
        chk("load_on_step_carry", Carry, 0);
        repeat (3) @(negedge Clk);
        chk("post_load_hold", Dig_dat, 16'h1204);
        @(negedge Clk);
        chk("post_load_step", Dig_dat, 16'h1205);
        Load = 1; Load_dat = 16'h0100;
        @(negedge Clk);
        Load = 0;
        repeat (2) @(negedge Clk);
        En = 0;
        repeat (5) @(negedge Clk);
        chk("freeze_dat", Dig_dat, 16'h0100);
        En = 1;
        @(negedge Clk);
        chk("resume_pre", Dig_dat, 16'h0100);
        @(negedge Clk);
        chk("resume_step", Dig_dat, 16'h0101);
        Load = 1; Load_dat = 16'h0057;
        @(negedge Clk);
        Load = 0;
        repeat (2) @(negedge Clk);
        chk("pre_reset_dat", Dig_dat, 16'h0057);
        #2 Reset = 1;
        #1;
        chk("async_rst_dig", Dig_dat, 16'h0000);
        chk("async_rst_carry", Carry, 0);
        chk("async_rst_tick", Scan_tick, 0);
        chk("async_rst_blank", Dig_blank, BLANK_RST);
        @(negedge Clk);
        Reset = 0;
        repeat (3) @(negedge Clk);
        chk("rst_release_hold", Dig_dat, 16'h0000);
        @(negedge Clk);
        chk("rst_release_step", Dig_dat, 16'h0001);
        En = 0;
        Load = 1; Load_dat = 16'h0030;
        @(negedge Clk);
`ifdef LZB_EN
        chk("blank_0030", Dig_blank, 4'b1100);
`else
        chk("blank_0030", Dig_blank, 4'b0000);
`endif
        Load_dat = 16'h0000;
        @(negedge Clk);
`ifdef LZB_EN
        chk("blank_0000", Dig_blank, 4'b1110);
`else
        chk("blank_0000", Dig_blank, 4'b0000);
`endif
        Load_dat = 16'h1000;
        @(negedge Clk);
        chk("blank_1000", Dig_blank, 4'b0000);
        Load_dat = 16'hABCD;
        @(negedge Clk);
        Load = 0;
        chk("invalid_all", Dig_dat, 16'h0000);
        @(negedge Clk);
        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
